// File: rtl/pmp_access_ctrl.sv
// Arbiter/sequencer sharing the single pmp checker between fetch and load/store
// checks, and serialising CSR accesses to pmpcfg/pmpaddr.
module pmp_access_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic [1:0]  if_priv,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic        if_fault,
  input  logic        ls_req,
  input  logic [31:0] ls_addr,
  input  logic [1:0]  ls_size,
  input  logic        ls_write,
  input  logic [1:0]  ls_priv,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic        ls_fault,
  input  logic        csr_req,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic        csr_gnt,
  output logic        csr_rvalid,
  output logic        csr_err,
  output logic [31:0] csr_rdata,
  output logic [31:0] pmp_addr,
  output logic [1:0]  pmp_size,
  output logic [1:0]  pmp_oper,
  output logic [1:0]  pmp_priv_mode,
  input  logic [1:0]  pmp_permission,
  output logic        pmp_wr_en,
  output logic [31:0] pmp_rw_addr,
  output logic [31:0] pmp_wdata,
  input  logic [31:0] pmp_rdata
);

  typedef enum logic [2:0] {
    IDLE, CHECK, RESP, CSR_WR, CSR_RD, CSR_RESP, SETTLE
  } state_t;

  state_t      r_state;
  logic        r_rr;        // 0: fetch wins a tie, 1: load/store wins
  logic        r_owner;     // 0: fetch owns the current check, 1: load/store
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic [1:0]  r_oper;
  logic [1:0]  r_priv;
  logic        r_fault;
  logic        r_csr_err;
  logic [31:0] r_csr_rdata;
  logic [31:0] r_rw_addr;
  logic [31:0] r_wdata;

  logic        w_idle;
  logic        w_csr_valid;
  logic        w_cfg_access;

  // Grants are masked while reset is held so nothing is accepted during reset.
  assign w_idle       = (r_state == IDLE) && !reset;
  assign w_csr_valid  = ((csr_addr >= 12'h3A0) && (csr_addr <= 12'h3A3)) ||
                        ((csr_addr >= 12'h3B0) && (csr_addr <= 12'h3BF));
  assign w_cfg_access = (r_state == CSR_WR) || (r_state == CSR_RD);

  assign csr_gnt = w_idle && csr_req;
  assign if_gnt  = w_idle && !csr_req && if_req && (!ls_req || !r_rr);
  assign ls_gnt  = w_idle && !csr_req && ls_req && (!if_req || r_rr);

  assign if_rvalid  = (r_state == RESP) && !r_owner;
  assign ls_rvalid  = (r_state == RESP) && r_owner;
  assign if_fault   = if_rvalid && r_fault;
  assign ls_fault   = ls_rvalid && r_fault;
  assign csr_rvalid = (r_state == CSR_RESP) || (r_state == SETTLE);
  assign csr_err    = (r_state == CSR_RESP) && r_csr_err;
  assign csr_rdata  = r_csr_rdata;

  assign pmp_addr      = r_addr;
  assign pmp_size      = r_size;
  assign pmp_oper      = r_oper;
  assign pmp_priv_mode = w_cfg_access ? 2'b00 : r_priv;
  assign pmp_wr_en     = (r_state == CSR_WR);
  assign pmp_rw_addr   = r_rw_addr;
  assign pmp_wdata     = r_wdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rr        <= 1'b0;
      r_owner     <= 1'b0;
      r_addr      <= '0;
      r_size      <= '0;
      r_oper      <= '0;
      r_priv      <= 2'b01;
      r_fault     <= 1'b0;
      r_csr_err   <= 1'b0;
      r_csr_rdata <= '0;
      r_rw_addr   <= '0;
      r_wdata     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (csr_gnt) begin
            r_csr_err   <= !w_csr_valid;
            r_csr_rdata <= '0;
            if (!w_csr_valid) begin
              r_state <= CSR_RESP;
            end else begin
              r_rw_addr <= {20'b0, csr_addr};
              if (csr_we) begin
                r_wdata <= csr_wdata;
                r_state <= CSR_WR;
              end else begin
                r_state <= CSR_RD;
              end
            end
          end else if (if_gnt) begin
            r_owner <= 1'b0;
            r_addr  <= if_addr;
            r_size  <= 2'b11;
            r_oper  <= 2'b10;
            r_priv  <= if_priv;
            if (ls_req) r_rr <= 1'b1;
            r_state <= CHECK;
          end else if (ls_gnt) begin
            r_owner <= 1'b1;
            r_addr  <= ls_addr;
            r_size  <= ls_size;
            r_oper  <= ls_write ? 2'b01 : 2'b00;
            r_priv  <= ls_priv;
            if (if_req) r_rr <= 1'b0;
            r_state <= CHECK;
          end
        end
        CHECK: begin
          r_fault <= (pmp_permission != 2'b11);
          r_state <= RESP;
        end
        RESP:     r_state <= IDLE;
        CSR_WR:   r_state <= SETTLE;
        SETTLE:   r_state <= IDLE;
        CSR_RD: begin
          r_csr_rdata <= pmp_rdata;
          r_state     <= CSR_RESP;
        end
        CSR_RESP: r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pmp_access_ctrl.md
# pmp_access_ctrl

Sequencer and arbiter in front of the single `pmp` checker. It shares the PMP check port between the instruction-fetch requester and the load/store requester, and serialises CSR reads and writes of pmpcfg0–3 and pmpaddr0–15 from the CSR unit. A check never overlaps a configuration update, and every check sees fully settled configuration.

## Interface
- No parameters. Data and address width is fixed at 32. CSR address width is fixed at 12.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `if_req` in 1, `if_addr` in 32, `if_priv` in 2: fetch check request, held until granted.
- `if_gnt` out 1, `if_rvalid` out 1, `if_fault` out 1: fetch grant, result strobe, fault flag.
- `ls_req` in 1, `ls_addr` in 32, `ls_size` in 2, `ls_write` in 1, `ls_priv` in 2: load/store check request.
- `ls_gnt` out 1, `ls_rvalid` out 1, `ls_fault` out 1: load/store grant, result strobe, fault flag.
- `csr_req` in 1, `csr_we` in 1, `csr_addr` in 12, `csr_wdata` in 32: CSR access request.
- `csr_gnt` out 1, `csr_rvalid` out 1, `csr_err` out 1, `csr_rdata` out 32: CSR grant and response.
- `pmp_addr` out 32, `pmp_size` out 2, `pmp_oper` out 2, `pmp_priv_mode` out 2: check port to `pmp`.
- `pmp_permission` in 2: check result from `pmp`. 2'b11 means allowed; any other value means denied.
- `pmp_wr_en` out 1, `pmp_rw_addr` out 32, `pmp_wdata` out 32, `pmp_rdata` in 32: register port to `pmp`.

## Operation
- States: IDLE, CHECK, RESP, CSR_WR, CSR_RD, CSR_RESP, SETTLE.
- Arbitration in IDLE only.
  - `csr_req` has highest priority.
  - Between `if_req` and `ls_req`, round-robin. The pointer flips to the other requester after each check grant made while both are requesting.
  - The pointer resets to favour fetch.
- Grants are combinational one-cycle pulses, asserted in IDLE in the accepting cycle. At most one grant is high per cycle.
- On a check grant, latch the request fields.
  - Fetch: oper=EXEC (2'b10), size=2'b11.
  - Load/store: oper=WRITE (2'b01) if `ls_write`, else READ (2'b00); size=`ls_size`.
  - Priv is taken from the request.
  - Go to CHECK.
- CHECK: drive the latched fields on `pmp_*`. At the end of the cycle, register fault = (`pmp_permission` != 2'b11). Go to RESP.
- RESP: pulse the owner's `*_rvalid` for one cycle with the registered fault. Go to IDLE.
- CSR address decode:
  - Valid: 0x3A0–0x3A3 and 0x3B0–0x3BF.
  - Invalid address: no PMP access. Go to CSR_RESP with `csr_err`=1 and `csr_rdata`=0.
- Valid CSR write: go to CSR_WR.
  - CSR_WR drives `pmp_wr_en`=1, `pmp_rw_addr`={20'b0,`csr_addr`}, `pmp_wdata`=`csr_wdata`, `pmp_priv_mode`=2'b00 for exactly one cycle.
  - Then SETTLE.
- SETTLE: one cycle, no check or CSR grant. Pulse `csr_rvalid` with `csr_err`=0. Go to IDLE.
- Valid CSR read: go to CSR_RD.
  - CSR_RD drives `pmp_rw_addr` and `pmp_priv_mode`=2'b00, with `pmp_wr_en`=0.
  - Register `pmp_rdata` at the end of the cycle. Go to CSR_RESP.
- CSR_RESP: pulse `csr_rvalid`. `csr_rdata` is the registered value. Go to IDLE.
- Outside CSR_WR and CSR_RD, `pmp_priv_mode` carries the latched check priv. Its reset value is 2'b01.
- A request dropped before its grant is simply not served. Requests arriving while busy wait; there is no queue beyond the held `*_req`.

## Timing
- Reset values:
  - state=IDLE, rr pointer=fetch.
  - All `*_gnt`, `*_rvalid`, `*_fault`, `csr_err`, `pmp_wr_en` = 0.
  - `csr_rdata`, `pmp_addr`, `pmp_rw_addr`, `pmp_wdata` = 0; `pmp_size`, `pmp_oper` = 0; `pmp_priv_mode`=2'b01.
- Check latency: grant in cycle N, `pmp_*` valid in N+1, `*_rvalid` in N+2. Throughput is one check per 3 cycles.
- CSR write: grant N, `pmp_wr_en` N+1, `csr_rvalid` N+2. The earliest next grant is N+3.
- CSR read: grant N, `csr_rvalid`/`csr_rdata` N+2.
- Invalid CSR: grant N, `csr_rvalid`+`csr_err` N+1.
- Simultaneous `csr_req`+`if_req`+`ls_req` in IDLE: CSR is served first, then the rr winner, then the other requester.
- Reset asserted mid-operation:
  - Immediately return to IDLE.
  - No pending `rvalid` is issued.
  - `pmp_wr_en` drops asynchronously.
  - In-flight requests are lost and requesters must re-present.

## Test plan
- Fetch check on a pmp programmed R/X allow (`pmp_permission`=2'b11), `if_addr`=0x0000_1000 -> `if_gnt` at N, `pmp_oper`=2'b10 and `pmp_size`=2'b11 at N+1, `if_rvalid`=1 and `if_fault`=0 at N+2.
- Load/store write with `pmp_permission`=2'b01, `ls_addr`=0x2000_0004, `ls_size`=2'b01 -> `pmp_oper`=2'b01 at N+1, `ls_rvalid`=1 and `ls_fault`=1 at N+2.
- `if_req` and `ls_req` held high together for 4 checks -> grant order fetch, ls, fetch, ls, with grants 3 cycles apart.
- CSR write 0x3B2 = 0x1234_5678, then CSR read 0x3B2 -> one `pmp_wr_en` pulse with `pmp_rw_addr`=0x3B2, SETTLE cycle with no grants, read returns `csr_rdata`=0x1234_5678 and `csr_err`=0.
- CSR read at 0x3C0 -> no `pmp_wr_en`, `csr_rvalid` at N+1 with `csr_err`=1 and `csr_rdata`=0.
- Assert `reset` during CHECK of a fetch -> no `if_rvalid` is issued. After release, the held `if_req` is re-granted from IDLE with the fetch-first pointer.
